// File: rtl/memory_stage_lsu.sv
// -----------------------------------------------------------------------------
// memory_stage_lsu
// MEM-stage load/store unit plus the MEM/WB pipeline register.
// Consumes the EX/MEM register outputs (em_*). It runs a req/gnt/rvalid
// data-memory transaction for loads and stores and stalls the pipeline until
// that transaction completes. It then registers the writeback data, the
// destination register and the write enable. ALU and jump instructions pass
// through in one cycle with no stall.
//
// Parameters
//   MAX_WAIT   : REQ/WAIT cycles allowed before a transaction times out (1..255)
//   ADDR_WIDTH : width of dmem_addr_o
//
// Optional feature (compile-time macro)
//   LSU_MISALIGN_TRAP_EN : misaligned H/W accesses raise bus_err_o and issue
//                          no request.
//
// Ports
//   clk_i, reset_i         clock (rising edge), asynchronous active-high reset
//   em_*                   EX/MEM controls, address, store data and link value
//   dmem_req_o/we/addr/be/wdata, dmem_gnt_i/rvalid_i/rdata_i : data-memory bus
//   mem_stall_o            while high, upstream holds the EX/MEM contents
//   mw_reg_write_o, mw_write_addr_reg_o, mw_wb_data_o : MEM/WB register
//   bus_err_o              one-cycle pulse on timeout or misalign trap
// -----------------------------------------------------------------------------
module memory_stage_lsu #(
    parameter int MAX_WAIT   = 255,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  em_reg_write_i,
    input  logic                  em_mem_read_i,
    input  logic                  em_mem_write_i,
    input  logic [1:0]            em_dmem_to_reg_i,
    input  logic [2:0]            em_funct3_i,
    input  logic [4:0]            em_write_addr_reg_i,
    input  logic [31:0]           em_alu_result_i,
    input  logic [31:0]           em_read_data2_i,
    input  logic [31:0]           em_pc_new_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [31:0]           dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [31:0]           dmem_rdata_i,
    output logic                  mem_stall_o,
    output logic                  mw_reg_write_o,
    output logic [4:0]            mw_write_addr_reg_o,
    output logic [31:0]           mw_wb_data_o,
    output logic                  bus_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // The counter value seen during the last allowed REQ/WAIT cycle
    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [7:0]            r_cnt;
    logic [ADDR_WIDTH-1:2] r_addr;
    logic                  r_we;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic                  r_mw_reg_write;
    logic [4:0]            r_mw_rd;
    logic [31:0]           r_mw_wb;
    logic                  r_bus_err;

    logic                  w_mem_op;
    logic                  w_is_store;
    logic                  w_size_b;
    logic                  w_size_h;
    logic                  w_misalign;
    logic                  w_timeout;
    logic [1:0]            w_lane;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load_data;
    logic [31:0]           w_wb_data;
    logic                  w_stall;
    logic                  w_err;

    assign w_mem_op   = em_mem_read_i | em_mem_write_i;
    // Read and write both set is treated as a load
    assign w_is_store = em_mem_write_i & ~em_mem_read_i;
    assign w_lane     = em_alu_result_i[1:0];
    assign w_size_b   = (em_funct3_i == 3'b000) || (em_funct3_i == 3'b100);
    assign w_size_h   = (em_funct3_i == 3'b001) || (em_funct3_i == 3'b101);
    assign w_timeout  = (r_cnt == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = w_mem_op &
                        ((w_size_h & w_lane[0]) |
                         (~w_size_b & ~w_size_h & (w_lane != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    // Store byte enables and lane-replicated write data
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = em_read_data2_i;
        if (w_size_b) begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{em_read_data2_i[7:0]}};
        end else if (w_size_h) begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{em_read_data2_i[15:0]}};
        end else begin
            w_be    = 4'b1111;
            w_wdata = em_read_data2_i;
        end
    end

    // Load lane extraction with sign/zero extension (funct3[2] = unsigned)
    always_comb begin
        w_byte      = 8'h00;
        w_load_data = dmem_rdata_i;
        case (w_lane)
            2'b00:   w_byte = dmem_rdata_i[7:0];
            2'b01:   w_byte = dmem_rdata_i[15:8];
            2'b10:   w_byte = dmem_rdata_i[23:16];
            default: w_byte = dmem_rdata_i[31:24];
        endcase
        w_half = w_lane[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        if (w_size_b) begin
            w_load_data = em_funct3_i[2] ? {24'h000000, w_byte}
                                         : {{24{w_byte[7]}}, w_byte};
        end else if (w_size_h) begin
            w_load_data = em_funct3_i[2] ? {16'h0000, w_half}
                                         : {{16{w_half[15]}}, w_half};
        end else begin
            w_load_data = dmem_rdata_i;
        end
    end

    // Writeback source select
    always_comb begin
        w_wb_data = em_alu_result_i;
        case (em_dmem_to_reg_i)
            2'b01:   w_wb_data = w_load_data;
            2'b10:   w_wb_data = em_pc_new_i;
            default: w_wb_data = em_alu_result_i;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; a store grant completes, and a timeout wins over a load grant
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op && !w_misalign) w_next_state = S_REQ;
                else                         w_next_state = S_IDLE;
            end
            S_REQ: begin
                if (dmem_gnt_i && r_we) w_next_state = S_IDLE;
                else if (w_timeout)     w_next_state = S_IDLE;
                else if (dmem_gnt_i)    w_next_state = S_WAIT;
                else                    w_next_state = S_REQ;
            end
            S_WAIT: begin
                if (dmem_rvalid_i)  w_next_state = S_IDLE;
                else if (w_timeout) w_next_state = S_IDLE;
                else                w_next_state = S_WAIT;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: stall and error for the current cycle
    always_comb begin
        w_stall = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_misalign) begin
                    w_stall = 1'b0;
                    w_err   = 1'b1;
                end else begin
                    w_stall = w_mem_op;
                    w_err   = 1'b0;
                end
            end
            S_REQ: begin
                if (dmem_gnt_i && r_we) begin
                    w_stall = 1'b0;
                    w_err   = 1'b0;
                end else if (w_timeout) begin
                    w_stall = 1'b0;
                    w_err   = 1'b1;
                end else begin
                    w_stall = 1'b1;
                    w_err   = 1'b0;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    w_stall = 1'b0;
                    w_err   = 1'b0;
                end else if (w_timeout) begin
                    w_stall = 1'b0;
                    w_err   = 1'b1;
                end else begin
                    w_stall = 1'b1;
                    w_err   = 1'b0;
                end
            end
            default: begin
                w_stall = 1'b0;
                w_err   = 1'b0;
            end
        endcase
    end

    // Latch the bus request when leaving IDLE; it is held for the whole transaction
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_wdata <= 32'h00000000;
        end else if (r_state == S_IDLE && w_next_state == S_REQ) begin
            r_addr  <= em_alu_result_i[ADDR_WIDTH-1:2];
            r_we    <= w_is_store;
            r_be    <= w_be;
            r_wdata <= w_wdata;
        end
    end

    // Wait counter: zero in IDLE, so it starts at 0 on entering REQ
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // MEM/WB register: bubble on stall cycles, suppress the write on an error
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_mw_reg_write <= 1'b0;
            r_mw_rd        <= 5'd0;
            r_mw_wb        <= 32'h00000000;
            r_bus_err      <= 1'b0;
        end else if (w_stall) begin
            r_mw_reg_write <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            r_mw_reg_write <= em_reg_write_i & ~w_err;
            r_mw_rd        <= em_write_addr_reg_i;
            r_mw_wb        <= w_wb_data;
            r_bus_err      <= w_err;
        end
    end

    assign dmem_req_o          = (r_state == S_REQ);
    assign dmem_we_o           = r_we;
    assign dmem_addr_o         = {r_addr, 2'b00};
    assign dmem_be_o           = r_be;
    assign dmem_wdata_o        = r_wdata;
    // Gated so the stall drops during reset even while a mem op is presented
    assign mem_stall_o         = w_stall & ~reset_i;
    assign mw_reg_write_o      = r_mw_reg_write;
    assign mw_write_addr_reg_o = r_mw_rd;
    assign mw_wb_data_o        = r_mw_wb;
    assign bus_err_o           = r_bus_err;

endmodule
